fir_mac_sequencer: RTL

Initiator side of the FIR core's ALU operand interface. Accepts input samples over a valid/ready stream and keeps a TAPS-deep sample delay line plus a coefficient register file. For each sample it issues TAPS multiply operations (a = sample, b = coefficient, select = 2'b01) to the alu and accumulates the returned products. It presents one filtered output per accepted sample on a valid/ready stream.

---
 rtl/fir_mac_sequencer_if.sv | 38 +++
 rtl/fir_mac_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Operand/stream bundle between the FIR MAC sequencer and its environment (sample source, ALU, sink).
// master = sequencer side, slave = environment side.
interface fir_mac_sequencer_if #(
    parameter int TAPS   = 64,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [DATA_W-1:0] coef_wdata;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;

    logic signed [DATA_W-1:0] alu_a;
    logic signed [DATA_W-1:0] alu_b;
    logic [1:0]               alu_select;
    logic signed [31:0]       alu_result;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ovf;
    logic                     busy;

    modport master (
        input  coef_we, coef_addr, coef_wdata, in_valid, in_data, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_select, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        output coef_we, coef_addr, coef_wdata, in_valid, in_data, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_select, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR MAC sequencer: one multiply per tap through an external ALU; output valid TAPS+ALU_LAT+1 cycles after accept,
// one sample in flight, output held stable until out_ready. FIR_SAT_EN selects saturating accumulation.
module fir_mac_sequencer #(
    parameter int TAPS    = 64,
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int ALU_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_mac_sequencer_if.master  bus
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [DATA_W-1:0] r_h [TAPS];
    logic [AW-1:0]            r_k;
    logic [ALU_LAT-1:0]       r_pipe;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovf;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_alu_a;
    logic signed [DATA_W-1:0] r_alu_b;
    logic [1:0]               r_alu_sel;

    logic                     w_accept;
    logic                     w_coef_ok;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_clip;

    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    assign w_coef_ok = bus.coef_we && (r_state == IDLE) && (32'(bus.coef_addr) < 32'(TAPS));

`ifdef FIR_SAT_EN
    // One guard bit exposes signed overflow of the add; clip to the nearest rail.
    logic signed [ACC_W:0] w_sum;
    always_comb begin
        w_sum      = {r_acc[ACC_W-1], r_acc} + (ACC_W+1)'(bus.alu_result);
        w_clip     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_clip) begin
            w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_acc_next = r_acc + ACC_W'(bus.alu_result);
    assign w_clip     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_pipe      <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 2'b00;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_h[i] <= '0;
            end
        end else begin
            // Tail of the pipe marks the cycle alu_result belongs to one of our issues.
            r_pipe[0] <= (r_state == ISSUE);
            for (int i = 1; i < ALU_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (r_pipe[ALU_LAT-1]) begin
                r_acc <= w_acc_next;
                if (w_clip) begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_coef_ok) begin
                r_h[bus.coef_addr] <= bus.coef_wdata;
            end

            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= 2'b00;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            r_x[i] <= r_x[i-1];
                        end
                        r_x[0]  <= bus.in_data;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_k     <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_alu_a   <= r_x[r_k];
                    r_alu_b   <= r_h[r_k];
                    r_alu_sel <= 2'b01;
                    r_k       <= r_k + 1'b1;
                    if (r_k == AW'(TAPS - 1)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_pipe == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == IDLE) && !rst;
    assign bus.busy       = (r_state != IDLE);
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_select = r_alu_sel;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_acc;
    assign bus.out_ovf    = r_ovf;
endmodule
